// File: rtl/ahb2wb.sv
// ahb2wb: AHB-Lite slave to Wishbone classic master bridge.
// Each accepted NONSEQ/SEQ transfer becomes one Wishbone single cycle.
// Wishbone ack_i drives AHB hready during the data phase.
// Optional build macro: HSIZE_CHECK_EN. When it is defined, a non-word hsize
// produces a two-cycle AHB ERROR response and no Wishbone cycle.
module ahb2wb #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [AWIDTH-1:0] haddr,
  input  logic              hwrite,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [DWIDTH-1:0] hwdata,
  output logic [DWIDTH-1:0] hrdata,
  output logic              hready,
  output logic [1:0]        hresp,
  output logic              clk_i,
  output logic              rst_i,
  output logic [AWIDTH-1:0] adr_o,
  output logic [DWIDTH-1:0] dat_o,
  input  logic [DWIDTH-1:0] dat_i,
  output logic              we_o,
  output logic              cyc_o,
  output logic              stb_o,
  input  logic              ack_i
);

  // state  | meaning
  // S_IDLE | no Wishbone cycle in progress, hready high
  // S_DATA | AHB data phase, Wishbone cycle running, hready follows ack_i
  // S_ERR1 | first ERROR cycle (hready low, hresp ERROR)
  // S_ERR2 | second ERROR cycle (hready high, hresp ERROR)
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t            state;
  logic              cyc_q;
  logic [DWIDTH-1:0] hrdata_q;
  logic              in_data;
  logic              accept;
  logic              size_ok;

  assign clk_i   = hclk;
  assign rst_i   = ~hresetn;
  assign in_data = (state == S_DATA);
  assign accept  = hsel & hready & htrans[1];

`ifdef HSIZE_CHECK_EN
  assign size_ok = (hsize == 3'b010);
  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0]};
`else
  // Without the size check every accepted transfer is treated as a word.
  assign size_ok = 1'b1;
  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0], hsize};
`endif

  // AHB handshake: wait states come straight from the Wishbone ack.
  always_comb begin
    hready = 1'b1;
    hresp  = 2'b00;
    case (state)
      S_DATA:  hready = ack_i;
      S_ERR1:  begin hready = 1'b0; hresp = 2'b01; end
      S_ERR2:  begin hready = 1'b1; hresp = 2'b01; end
      default: hready = 1'b1;
    endcase
  end

  // Data steering: write data passes through only during a write data phase,
  // read data passes through during a read data phase and is held otherwise.
  always_comb begin
    dat_o  = (in_data && we_o) ? hwdata : '0;
    hrdata = (in_data && !we_o) ? dat_i : hrdata_q;
  end

  assign cyc_o = cyc_q;
  assign stb_o = cyc_q;

  // Bridge FSM with registered Wishbone address/control.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= S_IDLE;
      cyc_q    <= 1'b0;
      adr_o    <= '0;
      we_o     <= 1'b0;
      hrdata_q <= '0;
    end else begin
      if (in_data && ack_i && !we_o)
        hrdata_q <= dat_i;
      if (state == S_ERR1) begin
        state <= S_ERR2;
        cyc_q <= 1'b0;
      end else if (in_data && !ack_i) begin
        // Wait state: everything on the Wishbone side holds.
        state <= S_DATA;
      end else if (accept && size_ok) begin
        // Covers both a fresh cycle and a back-to-back pipelined address.
        adr_o <= haddr;
        we_o  <= hwrite;
        state <= S_DATA;
        cyc_q <= 1'b1;
      end else if (accept) begin
        state <= S_ERR1;
        cyc_q <= 1'b0;
      end else begin
        state <= S_IDLE;
        cyc_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb2wb.sv
// tb_ahb2wb: randomized AHB master + Wishbone slave bench for ahb2wb.
// Expected values come from a transfer-level model: a queue of AHB transfers,
// an array holding what each address should contain, and the rule that the
// transfer in its data phase owns the Wishbone bus.
module tb_ahb2wb;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic [1:0]    hresp;
  logic          clk_i;
  logic          rst_i;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i;
  logic          we_o;
  logic          cyc_o;
  logic          stb_o;
  logic          ack_i;

  ahb2wb #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr),
    .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .clk_i(clk_i), .rst_i(rst_i), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .ack_i(ack_i)
  );

  always #5 hclk = ~hclk;

  // Wishbone slave: 16-word memory.
  logic [DW-1:0] mem [0:15];
  assign dat_i = mem[adr_o[3:0]];
  always @(posedge hclk)
    if (cyc_o && stb_o && we_o && ack_i) mem[adr_o[3:0]] <= dat_o;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] data;
  } xfer_t;

  xfer_t         q[$];
  logic [DW-1:0] model [0:15];
  logic [DW-1:0] last_rd;
  int            n_pass = 0;
  int            n_total = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive_hsize();
`ifdef HSIZE_CHECK_EN
    hsize = 3'b010;
`else
    hsize = 3'($urandom);
`endif
  endtask

  // Runs every transfer in q with a pipelined AHB master. Caller enters and
  // leaves just after a rising edge.
  task automatic run_queue(input int wmin, input int wmax, input int gap_max);
    xfer_t dp, ap;
    bit    dp_v, ap_v, rdy_exp;
    int    waits, gap, budget;
    dp_v = 0; ap_v = 0; gap = 0; budget = 0; waits = 0;
    dp = '0; ap = '0;
    while ((q.size() > 0 || dp_v || ap_v) && budget < 5000) begin
      budget++;
      if (!ap_v && q.size() > 0) begin
        if (gap == 0) begin
          ap = q.pop_front(); ap_v = 1; gap = $urandom_range(0, gap_max);
        end else gap--;
      end
      hburst = 3'($urandom);
      drive_hsize();
      if (ap_v) begin
        hsel = 1'b1; htrans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
        haddr = ap.addr; hwrite = ap.wr;
      end else begin
        case ($urandom_range(0, 2))
          0: begin hsel = 1'b1; htrans = 2'b00; end
          1: begin hsel = 1'b1; htrans = 2'b01; end
          default: begin hsel = 1'b0; htrans = 2'b10; end
        endcase
        haddr = 16'($urandom); hwrite = 1'($urandom);
      end
      hwdata = (dp_v && dp.wr) ? dp.data : $urandom;
      ack_i = dp_v && (waits == 0);
      rdy_exp = dp_v ? ack_i : 1'b1;

      @(negedge hclk);
      check("hready", hready, rdy_exp);
      check("hresp", hresp, 2'b00);
      check("cyc", cyc_o, dp_v);
      check("stb", stb_o, dp_v);
      if (dp_v) begin
        check("adr", adr_o, dp.addr);
        check("we", we_o, dp.wr);
        if (dp.wr) check("dat_o", dat_o, dp.data);
        else if (ack_i) check("hrdata", hrdata, model[dp.addr[3:0]]);
      end else check("dat_o_idle", dat_o, '0);
      if (!(dp_v && !dp.wr)) check("hrdata_hold", hrdata, last_rd);

      @(posedge hclk); #1;
      if (dp_v && ack_i) begin
        if (dp.wr) model[dp.addr[3:0]] = dp.data;
        else last_rd = model[dp.addr[3:0]];
        dp_v = 0;
      end else if (dp_v) waits--;
      if (ap_v && rdy_exp) begin
        dp = ap; dp_v = 1; ap_v = 0; waits = $urandom_range(wmin, wmax);
      end
    end
    check("queue_done_in_budget", 32'(budget < 5000), 32'd1);
    hsel = 1'b0; htrans = 2'b00; ack_i = 1'b0;
  endtask

  initial begin
    hresetn = 1'b0; hsel = 1'b0; haddr = '0; hwrite = 1'b0; htrans = 2'b00;
    hsize = 3'b010; hburst = 3'b000; hwdata = '0; ack_i = 1'b0;
    last_rd = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;

    #3;
    check("rst_hready", hready, 1'b1);
    check("rst_hresp", hresp, 2'b00);
    check("rst_cyc", cyc_o, 1'b0);
    check("rst_stb", stb_o, 1'b0);
    check("rst_we", we_o, 1'b0);
    check("rst_adr", adr_o, '0);
    check("rst_hrdata", hrdata, '0);
    check("rst_rst_i", rst_i, 1'b1);
    @(negedge hclk); hresetn = 1'b1; #1;
    check("rel_rst_i", rst_i, 1'b0);
    @(posedge hclk); #1;

    // Fill every slave location so the model and the memory agree.
    for (int i = 0; i < 16; i++) q.push_back('{addr: 16'(i), wr: 1'b1, data: $urandom});
    run_queue(0, 0, 0);

    // Back-to-back writes 1..4 with data 0..3, zero wait states.
    for (int n = 1; n <= 4; n++) q.push_back('{addr: 16'(n), wr: 1'b1, data: 32'(n - 1)});
    run_queue(0, 0, 0);
    @(negedge hclk);
    for (int n = 1; n <= 4; n++) check("mem_after_writes", mem[n], 32'(n - 1));
    @(posedge hclk); #1;

    // Three wait states per write.
    q.push_back('{addr: 16'd9, wr: 1'b1, data: 32'hA5A5_0009});
    q.push_back('{addr: 16'd10, wr: 1'b1, data: 32'hA5A5_000A});
    run_queue(3, 3, 0);

    // IDLE/BUSY/unselected gaps between writes.
    q.push_back('{addr: 16'd11, wr: 1'b1, data: 32'h0000_B00B});
    q.push_back('{addr: 16'd12, wr: 1'b1, data: 32'h0000_C00C});
    q.push_back('{addr: 16'd13, wr: 1'b1, data: 32'h0000_D00D});
    run_queue(0, 1, 2);

    // Reads 4..1 return 3..0.
    for (int n = 4; n >= 1; n--) q.push_back('{addr: 16'(n), wr: 1'b0, data: '0});
    run_queue(0, 0, 0);
    check("last_read_value", last_rd, 32'd0);

    // Random mix.
    for (int i = 0; i < 80; i++)
      q.push_back('{addr: 16'($urandom_range(0, 15)), wr: 1'($urandom), data: $urandom});
    run_queue(0, 3, 3);

    // Reset during a stalled write aborts the cycle at once.
    hsel = 1'b1; htrans = 2'b10; haddr = 16'd5; hwrite = 1'b1; drive_hsize(); ack_i = 1'b0;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hDEAD_BEEF;
    #2;
    check("abort_cyc_before", cyc_o, 1'b1);
    check("abort_hready_before", hready, 1'b0);
    hresetn = 1'b0; #1;
    check("abort_cyc", cyc_o, 1'b0);
    check("abort_stb", stb_o, 1'b0);
    check("abort_hready", hready, 1'b1);
    check("abort_rst_i", rst_i, 1'b1);
    @(negedge hclk); hresetn = 1'b1; last_rd = '0;
    @(posedge hclk); #1;
    @(negedge hclk);
    check("abort_mem_untouched", mem[5], model[5]);
    @(posedge hclk); #1;

`ifdef HSIZE_CHECK_EN
    hsel = 1'b1; htrans = 2'b10; haddr = 16'd7; hwrite = 1'b1; hsize = 3'b000;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hsize = 3'b010;
    check("err1_hready", hready, 1'b0);
    check("err1_hresp", hresp, 2'b01);
    check("err1_stb", stb_o, 1'b0);
    @(posedge hclk); #1;
    check("err2_hready", hready, 1'b1);
    check("err2_hresp", hresp, 2'b01);
    check("err2_stb", stb_o, 1'b0);
    @(posedge hclk); #1;
    check("err_after_hresp", hresp, 2'b00);
    check("err_after_stb", stb_o, 1'b0);
`endif

    // Traffic still works after the abort.
    for (int i = 0; i < 20; i++)
      q.push_back('{addr: 16'($urandom_range(0, 15)), wr: 1'($urandom), data: $urandom});
    run_queue(0, 2, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
